// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluation engine: per response bit, count rising edges of an oscillator
// pair over a fixed clock window and compare the two counts.
`timescale 1ns/1ps
module ro_puf_eval #(
  parameter int unsigned N_OSC     = 8,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned WINDOW    = 1024,
  parameter int unsigned RESP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_OSC-1:0]     osc_in,
  input  logic                 start,
  input  logic [SEL_W-1:0]     chal_a,
  input  logic [SEL_W-1:0]     chal_b,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] response,
  output logic [SEL_W:0]       tie_cnt,
  output logic                 err
);

  localparam int unsigned KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [2:0] {StIdle, StSettle, StCount, StCompare, StDone} state_e;

  state_e                 state_q, state_d;
  logic [N_OSC-1:0]       sync1_q, sync2_q, prev_q, osc_edge;
  logic [SEL_W-1:0]       chal_a_q, chal_b_q, sel_a, sel_b;
  logic [KW-1:0]          k_q;
  logic [TW-1:0]          timer_q;
  logic [CNT_W-1:0]       cnt_a_q, cnt_b_q;
  logic [RESP_BITS-1:0]   response_q;
  logic [SEL_W:0]         tie_q;
  logic                   err_q, chal_ok, last_bit, accept;

  // Note: rst_n is active-high here despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign osc_edge = sync2_q & ~prev_q;
  assign sel_a    = SEL_W'((32'(chal_a_q) + 32'(k_q)) % N_OSC);
  assign sel_b    = SEL_W'((32'(chal_b_q) + 32'(k_q)) % N_OSC);
  assign chal_ok  = (chal_a != chal_b) && (32'(chal_a) < N_OSC) && (32'(chal_b) < N_OSC);
  assign accept   = (state_q == StIdle) && start && ena;
  assign last_bit = (k_q == KW'(RESP_BITS - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept && chal_ok) state_d = StSettle;
      StSettle:  if (timer_q == TW'(1)) state_d = StCount;
      StCount:   if (timer_q == TW'(WINDOW - 1)) state_d = StCompare;
      StCompare: state_d = last_bit ? StDone : StSettle;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (!ena && (state_q != StIdle)) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      chal_a_q   <= '0;
      chal_b_q   <= '0;
      k_q        <= '0;
      timer_q    <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      response_q <= '0;
      tie_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      // Timer restarts on every state change; it times both SETTLE and COUNT.
      timer_q <= ((state_d != state_q) || (state_q == StIdle)) ? '0 : timer_q + 1'b1;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (chal_ok) begin
              chal_a_q   <= chal_a;
              chal_b_q   <= chal_b;
              k_q        <= '0;
              response_q <= '0;
              tie_q      <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StSettle: begin
          cnt_a_q <= '0;
          cnt_b_q <= '0;
        end
        StCount: begin
          if (osc_edge[sel_a] && (cnt_a_q != CntMax)) cnt_a_q <= cnt_a_q + 1'b1;
          if (osc_edge[sel_b] && (cnt_b_q != CntMax)) cnt_b_q <= cnt_b_q + 1'b1;
        end
        StCompare: begin
          response_q[k_q] <= (cnt_a_q > cnt_b_q);
          if (cnt_a_q == cnt_b_q) tie_q <= tie_q + 1'b1;
          if (!last_bit) k_q <= k_q + 1'b1;
        end
        default: ;
      endcase
      // Abort: never leave a partial response visible.
      if (!ena && (state_q != StIdle)) begin
        response_q <= '0;
        tie_q      <= '0;
      end
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    resp_valid = (state_q == StDone);
    response   = response_q;
    tie_cnt    = tie_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_ro_puf_eval.sv
// Bench for ro_puf_eval: clock-aligned periodic oscillators, directed and randomised challenges,
// checked against an edge-count model derived from oscillator periods.
`timescale 1ns/1ps
module tb_ro_puf_eval;
  localparam int unsigned W = 16, RB = 4, W2 = 32, RB2 = 2;

  logic clk = 1'b0, rst_n = 1'b1, ena = 1'b1, start = 1'b0, start2 = 1'b0;
  logic [2:0] chal_a = '0, chal_b = '0, chal_a2 = '0, chal_b2 = '0;
  logic [7:0] osc = '0;
  logic busy, valid, err, busy2, valid2, err2;
  logic [RB-1:0] response;
  logic [RB2-1:0] resp2;
  logic [3:0] tie_cnt, tie2;

  int unsigned per [8] = '{8, 8, 8, 8, 8, 8, 8, 8};
  int unsigned phase [8] = '{0, 1, 2, 3, 5, 7, 11, 13};
  int unsigned cyc = 0;
  int n_chk = 0, n_pass = 0;
  logic [31:0] last_exp;

  ro_puf_eval #(.N_OSC(8), .SEL_W(3), .CNT_W(16), .WINDOW(W), .RESP_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc), .start(start), .chal_a(chal_a),
    .chal_b(chal_b), .busy(busy), .resp_valid(valid), .response(response), .tie_cnt(tie_cnt),
    .err(err)
  );

  ro_puf_eval #(.N_OSC(8), .SEL_W(3), .CNT_W(3), .WINDOW(W2), .RESP_BITS(RB2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc), .start(start2), .chal_a(chal_a2),
    .chal_b(chal_b2), .busy(busy2), .resp_valid(valid2), .response(resp2), .tie_cnt(tie2),
    .err(err2)
  );

  always #5 clk = ~clk;

  // Square waves that change mid-cycle, each with a whole-cycle period.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 8; i++) osc[i] = (((cyc + phase[i]) % per[i]) < (per[i] / 2));
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Any W-cycle window holds exactly W/p rising edges when p divides W.
  function automatic int unsigned edges(input int unsigned p, input int unsigned w,
                                        input int unsigned maxv);
    int unsigned c = w / p;
    return (c > maxv) ? maxv : c;
  endfunction

  task automatic model(input int a, input int b, input int nbits, input int unsigned w,
                       input int unsigned maxv, output logic [31:0] resp, output int ties);
    int unsigned ca, cb;
    resp = '0;
    ties = 0;
    for (int k = 0; k < nbits; k++) begin
      ca = edges(per[(a + k) % 8], w, maxv);
      cb = edges(per[(b + k) % 8], w, maxv);
      resp[k] = (ca > cb);
      if (ca == cb) ties++;
    end
  endtask

  task automatic settle();
    repeat (40) @(posedge clk);
  endtask

  task automatic run_main(input int a, input int b, output int lat, output int busy_n,
                          output int vld_n);
    lat = -1;
    busy_n = 0;
    vld_n = 0;
    @(negedge clk);
    chal_a = 3'(a);
    chal_b = 3'(b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy) busy_n++;
    for (int i = 1; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_n++;
      if (valid) begin
        vld_n++;
        if (lat < 0) lat = i;
      end
      if (!busy) break;
    end
  endtask

  task automatic eval_main(input string tag, input int a, input int b);
    int lat, bn, vn, ties;
    logic [31:0] er;
    run_main(a, b, lat, bn, vn);
    model(a, b, RB, W, 65535, er, ties);
    last_exp = er;
    check({tag, "_response"}, 32'(response), er);
    check({tag, "_tie_cnt"}, 32'(tie_cnt), 32'(ties));
    check({tag, "_latency"}, 32'(lat), RB * (W + 3));
    check({tag, "_busy_cycles"}, 32'(bn), RB * (W + 3) + 1);
    check({tag, "_valid_pulses"}, 32'(vn), 1);
  endtask

  initial begin
    int lat, ties, a, b;
    logic [31:0] er;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_response", 32'(response), 0);
    check("rst_tie_cnt", 32'(tie_cnt), 0);
    check("rst_busy_sat", 32'(busy2), 0);
    @(negedge clk);
    rst_n = 1'b0;

    per = '{8, 8, 4, 8, 8, 16, 8, 8};
    settle();
    eval_main("t1", 2, 5);
    check("t1_literal", 32'(response), 32'(4'b0001));
    check("t1_tie_literal", 32'(tie_cnt), 2);

    eval_main("t2", 5, 2);
    check("t2_bit0", 32'(response[0]), 0);

    // Equal indices are rejected and leave the previous response alone.
    @(negedge clk);
    chal_a = 3'd3;
    chal_b = 3'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rej_err_pulse", 32'(err), 1);
    check("rej_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("rej_err_clear", 32'(err), 0);
    check("rej_busy_after", 32'(busy), 0);
    check("rej_response_kept", 32'(response), last_exp);

    // Saturating counters: period 2 vs period 4 over 32 cycles both clip at 7.
    per = '{2, 4, 8, 8, 8, 8, 8, 8};
    settle();
    @(negedge clk);
    chal_a2 = 3'd0;
    chal_b2 = 3'd1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = -1;
    for (int i = 1; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (valid2 && (lat < 0)) lat = i;
      if (!busy2) break;
    end
    model(0, 1, RB2, W2, 7, er, ties);
    check("sat_bit0", 32'(resp2[0]), 0);
    check("sat_response", 32'(resp2), er & 32'h3);
    check("sat_tie_cnt", 32'(tie2), 32'(ties));
    check("sat_latency", 32'(lat), RB2 * (W2 + 3));

    // Abort in the middle of bit 2's count window.
    per = '{8, 8, 4, 8, 8, 16, 8, 8};
    settle();
    @(negedge clk);
    chal_a = 3'd2;
    chal_b = 3'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 1);
    check("abort_partial_bit0", 32'(response[0]), 1);
    @(negedge clk);
    ena = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_response", 32'(response), 0);
    check("abort_tie_cnt", 32'(tie_cnt), 0);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (valid || busy) lat++;
    end
    check("abort_no_valid", 32'(lat), 0);
    @(negedge clk);
    ena = 1'b1;

    // Asynchronous reset while settling.
    settle();
    @(negedge clk);
    chal_a = 3'd2;
    chal_b = 3'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("arst_busy_before", 32'(busy), 1);
    #2;
    rst_n = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_valid", 32'(valid), 0);
    check("arst_err", 32'(err), 0);
    check("arst_response", 32'(response), 0);
    check("arst_tie_cnt", 32'(tie_cnt), 0);
    @(negedge clk);
    rst_n = 1'b0;
    settle();
    eval_main("arst_rerun", 2, 5);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) per[i] = 2 << $urandom_range(0, 3);
      a = int'($urandom_range(0, 7));
      b = (a + int'($urandom_range(1, 7))) % 8;
      settle();
      eval_main("rnd", a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ro_puf_eval.md
Name: ro_puf_eval

Overview:
Parametrised challenge/response evaluation engine for the ring-oscillator PUF. It takes N_OSC free-running oscillator outputs from the oscillator bank. For each response bit it selects an oscillator pair from the challenge, counts the pair's rising edges over a fixed clock window, compares the two counts and stores one response bit. It supersedes the fixed 8-way mux, free-running counter and comparator path: it adds a timed measurement window, a start/busy/valid handshake, multi-bit responses, tie detection and abort.

Parameters:
N_OSC, 8, number of oscillator inputs; must be at least 2.
SEL_W, 3, index width; equals ceil(log2(N_OSC)).
CNT_W, 16, edge-counter width; counters saturate.
WINDOW, 1024, clock cycles per count window; at least 1.
RESP_BITS, 8, response bits per challenge.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-high reset: asserted = 1, despite the suffix.
ena  in  1  block enable; 0 aborts any evaluation.
osc_in  in  N_OSC  raw oscillator outputs, asynchronous to clk.
start  in  1  request evaluation; sampled only in IDLE.
chal_a  in  SEL_W  first oscillator index of pair 0.
chal_b  in  SEL_W  second oscillator index of pair 0.
busy  out  1  high from accept until DONE ends.
resp_valid  out  1  one-cycle pulse when response is final.
response  out  RESP_BITS  response word; bit k comes from pair k.
tie_cnt  out  SEL_W+1  number of bits in the last response decided by equal counts (tie).
err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: state goes to IDLE. busy, resp_valid, err, response, tie_cnt, all counters and synchronisers go to 0.
- Each osc_in bit passes through a 2-flop synchroniser and then a rising-edge detector in the clk domain. Only oscillators slower than clk/2 count correctly; this is the integration contract with the bank.
- Pair for bit k: a_k = (chal_a + k) mod N_OSC, b_k = (chal_b + k) mod N_OSC. chal_a and chal_b are latched at accept. Indices of N_OSC or more are invalid.
- Accept: in IDLE with start=1 and ena=1.
  - If chal_a == chal_b, or either index is at least N_OSC: pulse err for one cycle and stay in IDLE. response is left unchanged.
  - Otherwise: clear response and tie_cnt, set k=0, go to SETTLE, raise busy.
- SETTLE (2 cycles): both pair counters are held at 0 so the synchroniser pipeline flushes after the mux change.
- COUNT (exactly WINDOW cycles):
  - cnt_a increments on each detected edge of osc a_k; cnt_b likewise for b_k.
  - Each counter saturates at 2^CNT_W - 1 and does not wrap.
- COMPARE (1 cycle):
  - response[k] = 1 if cnt_a > cnt_b, else 0.
  - If cnt_a == cnt_b (including both saturated): response[k] = 0 and tie_cnt increments.
  - If k == RESP_BITS-1, go to DONE; else k++ and return to SETTLE.
- DONE (1 cycle): resp_valid = 1, busy = 1, then go to IDLE with busy = 0.
- Latency: resp_valid is high exactly RESP_BITS*(WINDOW+3) cycles after the accept edge.
- start while busy: ignored; no err.
- response and tie_cnt hold their values after DONE until the next accepted start.
- ena=0 in any non-IDLE state: go to IDLE next cycle, busy drops, no resp_valid. response and tie_cnt are cleared, so a partial response is never exposed.
- rst_n asserted mid-evaluation: everything returns to reset values immediately (asynchronous).

Test Plan:
- Bench overrides WINDOW=16, RESP_BITS=4. Drive osc_in[2] with period 4 clk and osc_in[5] with period 16 clk; all other oscillators period 8. Start with chal_a=2, chal_b=5 -> pair 0 compares 2 vs 5, so response[0]=1. Pairs 1..3 (3/6, 4/7, 5/0) compare period 8 against period 8 for pairs 1 and 2 (ties), and period 16 against period 8 for pair 3, so response[3]=0. Required: response=4'b0001, tie_cnt=2, resp_valid exactly 76 cycles after accept.
- chal_a=5, chal_b=2 with the same stimulus -> response[0]=0 and tie_cnt=2; resp_valid is a single cycle and busy is high for 77 cycles.
- chal_a=chal_b=3 -> err pulses one cycle, busy stays 0, and the previous response is retained.
- Set CNT_W=3 and drive a period-2 oscillator against a period-4 oscillator with WINDOW=32 -> both counters saturate at 7, so the bit is 0 and the tie is counted.
- Drop ena mid-COUNT of bit 2 -> next cycle state is IDLE, busy=0, response=0, and no resp_valid pulse.
- Assert rst_n during SETTLE -> all outputs are 0 asynchronously. After release, a new start completes normally with the first test's values.
